// File: rtl/branch_pc_sequencer_if.sv
// Branch/adder bus for branch_pc_sequencer.
// master: the sequencer (consumes branch info and adder result, drives operands).
// slave : the ID-stage comparator plus the external adder.
interface branch_pc_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             br_valid;
    logic             br_taken;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_r;
    logic             add_sel;

    modport master (
        input  br_valid, br_taken, br_pc, br_offset, add_r,
        output add_a, add_b, add_sel
    );

    modport slave (
        output br_valid, br_taken, br_pc, br_offset, add_r,
        input  add_a, add_b, add_sel
    );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Program counter owner that time-shares one external adder between the
// sequential increment and the taken-branch target computation.
// Optional macro BR_STATS_EN adds saturating branch/taken counters.
module branch_pc_sequencer #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_INC   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       stall,
    branch_pc_sequencer_if.master      bus,
    output logic [WIDTH-1:0]           pc,
    output logic                       flush,
`ifdef BR_STATS_EN
    output logic                       busy,
    output logic [15:0]                br_count,
    output logic [15:0]                taken_count
`else
    output logic                       busy
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        RESOLVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] br_pc_q, br_pc_d;
    logic [WIDTH-1:0] br_off_q, br_off_d;
`ifdef BR_STATS_EN
    logic [15:0]      br_count_q, br_count_d;
    logic [15:0]      taken_count_q, taken_count_d;
`endif

    logic in_resolve;
    logic take_branch;

    assign in_resolve  = (state_q == RESOLVE);
    assign take_branch = !in_resolve && bus.br_valid && bus.br_taken;

    // Adder operand steering and state-decoded outputs (straight from the state flop)
    always_comb begin
        bus.add_a   = in_resolve ? br_pc_q  : pc_q;
        bus.add_b   = in_resolve ? br_off_q : PC_INC;
        bus.add_sel = in_resolve;
        flush       = in_resolve;
        busy        = in_resolve;
        pc          = pc_q;
    end

    // Next-state: taken branch beats stall; RESOLVE always loads the target
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        br_pc_d  = br_pc_q;
        br_off_d = br_off_q;
        case (state_q)
            RUN: begin
                if (take_branch) begin
                    br_pc_d  = bus.br_pc;
                    br_off_d = bus.br_offset;
                    state_d  = RESOLVE;
                end else if (!stall) begin
                    pc_d = bus.add_r;
                end
            end
            RESOLVE: begin
                pc_d    = bus.add_r;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

`ifdef BR_STATS_EN
    // Saturating statistics counters
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (!in_resolve && bus.br_valid && (br_count_q != 16'hFFFF))
            br_count_d = br_count_q + 16'd1;
        if (take_branch && (taken_count_q != 16'hFFFF))
            taken_count_d = taken_count_q + 16'd1;
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            br_pc_q       <= '0;
            br_off_q      <= '0;
`ifdef BR_STATS_EN
            br_count_q    <= '0;
            taken_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            br_pc_q       <= br_pc_d;
            br_off_q      <= br_off_d;
`ifdef BR_STATS_EN
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
`endif
        end
    end

endmodule
